// File: rtl/vga_plot_pkg.sv
// Shared constants and FSM encoding for the VGA plot arbiter and its helpers.
package vga_plot_pkg;

  localparam int SCREEN_WIDTH  = 160;
  localparam int SCREEN_HEIGHT = 120;
  localparam int DEF_X_W       = 8;
  localparam int DEF_Y_W       = 7;
  localparam int DEF_C_W       = 3;
  localparam int DEF_ADDR_W    = 15;
  localparam int DEF_ROM_LAT   = 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FILL  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    FILL  = ST_FILL,
    DRAIN = ST_DRAIN,
    DONE  = ST_DONE
  } fill_state_t;

  // Number of pixels in a full-screen fill of the given size.
  function automatic longint pixel_count(input int w, input int h);
    return longint'(w) * longint'(h);
  endfunction

endpackage

// File: rtl/vga_plot_arbiter_fill_addr_gen.sv
// Raster counter for the background fill: walks x, then y, and keeps a
// linear ROM address in step by plain increment (no multiplier).
module fill_addr_gen
  import vga_plot_pkg::*;
#(
  parameter int WIDTH  = SCREEN_WIDTH,
  parameter int HEIGHT = SCREEN_HEIGHT,
  parameter int X_W    = DEF_X_W,
  parameter int Y_W    = DEF_Y_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step,
  output logic [X_W-1:0]    x,
  output logic [Y_W-1:0]    y,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  localparam logic [X_W-1:0] X_LAST = X_W'(WIDTH - 1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(HEIGHT - 1);

  assign last = (x == X_LAST) && (y == Y_LAST);

  // Advance one pixel per step; after the final pixel everything wraps to 0.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      x    <= '0;
      y    <= '0;
      addr <= '0;
    end else if (step) begin
      if (last) begin
        x    <= '0;
        y    <= '0;
        addr <= '0;
      end else if (x == X_LAST) begin
        x    <= '0;
        y    <= y + Y_W'(1);
        addr <= addr + ADDR_W'(1);
      end else begin
        x    <= x + X_W'(1);
        addr <= addr + ADDR_W'(1);
      end
    end
  end

endmodule

// File: rtl/vga_plot_arbiter.sv
// Owns the vga_adapter write port and shares it between the background
// fill engine (ROM streamer, absolute priority) and game pixels (valid/ready).
module vga_plot_arbiter
  import vga_plot_pkg::*;
#(
  parameter int WIDTH   = SCREEN_WIDTH,
  parameter int HEIGHT  = SCREEN_HEIGHT,
  parameter int X_W     = DEF_X_W,
  parameter int Y_W     = DEF_Y_W,
  parameter int C_W     = DEF_C_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ROM_LAT = DEF_ROM_LAT
) (
  input  logic              iClock,
  input  logic              iReset,
  input  logic              iFillStart,
  output logic [ADDR_W-1:0] oRomAddr,
  input  logic [C_W-1:0]    iRomData,
  input  logic              iReqValid,
  output logic              oReqReady,
  input  logic [X_W-1:0]    iReqX,
  input  logic [Y_W-1:0]    iReqY,
  input  logic [C_W-1:0]    iReqColor,
  output logic [X_W-1:0]    oX,
  output logic [Y_W-1:0]    oY,
  output logic [C_W-1:0]    oColor,
  output logic              oPlot,
  output logic              oFillBusy,
  output logic              oFillDone
);

  if (ROM_LAT < 1 || ROM_LAT > 3) begin : g_bad_rom_lat
    $error("vga_plot_arbiter: ROM_LAT must be in 1..3");
  end

  if (pixel_count(WIDTH, HEIGHT) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("vga_plot_arbiter: ADDR_W too small for WIDTH*HEIGHT pixels");
  end

  fill_state_t state_q;
  fill_state_t state_d;

  logic              gen_clear;
  logic              gen_step;
  logic              gen_last;
  logic [X_W-1:0]    gen_x;
  logic [Y_W-1:0]    gen_y;
  logic [ADDR_W-1:0] gen_addr;

  logic              push;
  logic [ROM_LAT-1:0] pipe_valid;
  logic [X_W-1:0]    pipe_x [ROM_LAT];
  logic [Y_W-1:0]    pipe_y [ROM_LAT];
  logic              emerge;

  logic              req_ready;
  logic              fire;

  fill_addr_gen #(
    .WIDTH  (WIDTH),
    .HEIGHT (HEIGHT),
    .X_W    (X_W),
    .Y_W    (Y_W),
    .ADDR_W (ADDR_W)
  ) u_addr_gen (
    .clk   (iClock),
    .reset (iReset),
    .clear (gen_clear),
    .step  (gen_step),
    .x     (gen_x),
    .y     (gen_y),
    .addr  (gen_addr),
    .last  (gen_last)
  );

  assign oRomAddr  = gen_addr;
  assign emerge    = pipe_valid[ROM_LAT-1];
  assign oReqReady = req_ready && !iReset;
  assign fire      = iReqValid && oReqReady;
  assign oFillBusy = (state_q == FILL) || (state_q == DRAIN);
  assign oFillDone = (state_q == DONE);

  // State register; reset drops any fill in progress without a done pulse.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: the start cycle already issues address 0 so the first
  // plot lands ROM_LAT+1 cycles later; DONE waits until the pipe is empty,
  // which puts the done pulse one cycle after the last fill plot.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    gen_step  = 1'b0;
    gen_clear = 1'b0;
    push      = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = !iFillStart;
        if (iFillStart) begin
          push     = 1'b1;
          gen_step = 1'b1;
          state_d  = gen_last ? DRAIN : FILL;
        end
      end
      FILL: begin
        push     = 1'b1;
        gen_step = 1'b1;
        if (gen_last) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_valid == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        gen_clear = 1'b1;
        state_d   = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Coordinate shift register matching the ROM read latency, so each pixel's
  // (x, y) pops out in the same cycle as its colour from the ROM.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      pipe_valid <= '0;
      for (int i = 0; i < ROM_LAT; i++) begin
        pipe_x[i] <= '0;
        pipe_y[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= push;
      pipe_x[0]     <= gen_x;
      pipe_y[0]     <= gen_y;
      for (int i = 1; i < ROM_LAT; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        pipe_x[i]     <= pipe_x[i-1];
        pipe_y[i]     <= pipe_y[i-1];
      end
    end
  end

  // Output register toward vga_adapter; fill pixels and game pixels are
  // mutually exclusive because game beats are only accepted in IDLE.
  always_ff @(posedge iClock) begin
    if (iReset) begin
      oX     <= '0;
      oY     <= '0;
      oColor <= '0;
      oPlot  <= 1'b0;
    end else if (emerge) begin
      oX     <= pipe_x[ROM_LAT-1];
      oY     <= pipe_y[ROM_LAT-1];
      oColor <= iRomData;
      oPlot  <= 1'b1;
    end else if (fire) begin
      oX     <= iReqX;
      oY     <= iReqY;
      oColor <= iReqColor;
      oPlot  <= 1'b1;
    end else begin
      oPlot  <= 1'b0;
    end
  end

endmodule
